sum_four: RTL and testbench



---
 rtl/sum_four.sv | 87 ++++++++
 tb/tb_sum_four.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sum_four.sv
// sum_four: two 4-bit registered counts built on structural ripple-carry adders.
//   o_cnt_1 advances by STEP every clock edge; o_cnt_2 accumulates o_cnt_1.
//   All arithmetic is modulo 16 (adder carry-out is discarded).

// Single-bit full-adder cell.
module sum_four_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// 4-bit ripple-carry adder: four full-adder cells chained LSB first, carry-in 0.
module sum_four_rca4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] s_o,
  output logic       co_o
);
  logic [4:0] carry_s;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    sum_four_fa u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry_s[i]),
      .s_o (s_o[i]),
      .c_o (carry_s[i+1])
    );
  end

  assign co_o = carry_s[4];
endmodule

// Top: step counter plus running sum of the step counter.
module sum_four #(
  parameter logic [3:0] STEP = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] o_cnt_1,
  output logic [3:0] o_cnt_2
);
  logic [3:0] cnt1_q;
  logic [3:0] cnt2_q;
  logic [3:0] cnt1_d;
  logic [3:0] cnt2_d;
  // Carry-outs are intentionally dropped: the counts wrap modulo 16.
  logic       carry_a_unused_s;
  logic       carry_b_unused_s;

  // Adder A: next step-counter value.
  sum_four_rca4 u_add_a (
    .a_i  (cnt1_q),
    .b_i  (STEP),
    .s_o  (cnt1_d),
    .co_o (carry_a_unused_s)
  );

  // Adder B: accumulate the pre-update step-counter value.
  sum_four_rca4 u_add_b (
    .a_i  (cnt2_q),
    .b_i  (cnt1_q),
    .s_o  (cnt2_d),
    .co_o (carry_b_unused_s)
  );

  // State registers: cleared immediately by rst, both advance on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1_q <= 4'd0;
      cnt2_q <= 4'd0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign o_cnt_1 = cnt1_q;
  assign o_cnt_2 = cnt2_q;
endmodule

// File: tb/tb_sum_four.sv
// Directed bench for sum_four: reset hold, count-up/wrap table, async reset,
// STEP=5 and STEP=0 instances, and an exhaustive standalone adder sweep.
module tb_sum_four;
  logic       clk;
  logic       rst;
  logic [3:0] c1_s1, c2_s1;
  logic [3:0] c1_s5, c2_s5;
  logic [3:0] c1_s0, c2_s0;
  logic [3:0] ta, tb;
  logic [3:0] ts;
  logic       tco;

  int n_cmp;
  int n_err;

  typedef struct {
    int         k;
    logic [3:0] c1;
    logic [3:0] c2;
  } vec_t;

  vec_t tbl[12];

  sum_four #(.STEP(4'd1)) dut (.clk(clk), .rst(rst), .o_cnt_1(c1_s1), .o_cnt_2(c2_s1));
  sum_four #(.STEP(4'd5)) dut5 (.clk(clk), .rst(rst), .o_cnt_1(c1_s5), .o_cnt_2(c2_s5));
  sum_four #(.STEP(4'd0)) dut0 (.clk(clk), .rst(rst), .o_cnt_1(c1_s0), .o_cnt_2(c2_s0));
  sum_four_rca4 u_rca (.a_i(ta), .b_i(tb), .s_o(ts), .co_o(tco));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int edges;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    ta    = 4'd0;
    tb    = 4'd0;

    // k, o_cnt_1, o_cnt_2 for STEP=1 (o_cnt_2 = k(k-1)/2 mod 16)
    tbl[0]  = '{1,  4'd1,  4'd0};
    tbl[1]  = '{2,  4'd2,  4'd1};
    tbl[2]  = '{3,  4'd3,  4'd3};
    tbl[3]  = '{4,  4'd4,  4'd6};
    tbl[4]  = '{5,  4'd5,  4'd10};
    tbl[5]  = '{6,  4'd6,  4'd15};
    tbl[6]  = '{7,  4'd7,  4'd5};
    tbl[7]  = '{8,  4'd8,  4'd12};
    tbl[8]  = '{9,  4'd9,  4'd4};
    tbl[9]  = '{10, 4'd10, 4'd13};
    tbl[10] = '{16, 4'd0,  4'd8};
    tbl[11] = '{32, 4'd0,  4'd0};

    // Reset hold for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("hold_c1", c1_s1, 0);
      check("hold_c2", c2_s1, 0);
    end

    // Count-up and wrap, STEP=1
    rst   = 1'b0;
    edges = 0;
    for (int i = 0; i < 12; i++) begin
      while (edges < tbl[i].k) begin
        @(posedge clk);
        edges++;
      end
      @(negedge clk);
      check($sformatf("step1_c1_k%0d", tbl[i].k), c1_s1, tbl[i].c1);
      check($sformatf("step1_c2_k%0d", tbl[i].k), c2_s1, tbl[i].c2);
    end

    // Re-reset, then STEP=5 / STEP=0 sequences alongside STEP=1
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rerst_c1", c1_s1, 0);
    check("rerst_c2", c2_s5, 0);
    rst = 1'b0;

    @(posedge clk); @(negedge clk);
    check("s5_c1_e1", c1_s5, 5);  check("s5_c2_e1", c2_s5, 0);
    @(posedge clk); @(negedge clk);
    check("s5_c1_e2", c1_s5, 10); check("s5_c2_e2", c2_s5, 5);
    @(posedge clk); @(negedge clk);
    check("s5_c1_e3", c1_s5, 15); check("s5_c2_e3", c2_s5, 15);
    @(posedge clk); @(negedge clk);
    check("s5_c1_e4", c1_s5, 4);  check("s5_c2_e4", c2_s5, 14);
    check("s0_c1_e4", c1_s0, 0);  check("s0_c2_e4", c2_s0, 0);

    // Async reset mid-run: STEP=1 is at edge 4, advance to edge 7
    repeat (3) @(posedge clk);
    #1;
    check("pre_async_c1", c1_s1, 7);
    check("pre_async_c2", c2_s1, 5);
    rst = 1'b1;
    #1;
    check("async_c1", c1_s1, 0);
    check("async_c2", c2_s1, 0);
    #1;
    check("async_c1_b", c1_s5, 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_async_c1", c1_s1, 1);
    check("post_async_c2", c2_s1, 0);
    check("s0_c1_end", c1_s0, 0);

    // Exhaustive standalone ripple-carry adder
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ta = a[3:0];
        tb = b[3:0];
        #1;
        check($sformatf("rca_%0d_%0d", a, b), {tco, ts}, a + b);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
